e_mdu: RTL and testbench

//  E-stage multiply/divide unit. Consumes the rs/rt operands that the D-stage register file reads
//  (after D/E latching and forwarding) and produces HI/LO results for mult/multu/div/divu.

---
 rtl/e_mdu.sv | 139 +++++++++++++
 tb/tb_e_mdu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div into HI/LO.
// Ports: clk, reset(n), rs/rt/op/start, D use -> busy, stall, result, HI, LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic [3:0]  E_mdu_op,
  input  logic        E_mdu_start,
  input  logic        D_mdu_use,
  output logic        E_mdu_busy,
  output logic        E_mdu_stall,
  output logic [31:0] E_mdu_result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MaxCyc =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MaxCyc + 1);

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } mduOp_e;

  logic [CW-1:0] count;
  logic          busy;
  logic [31:0]   hiS;
  logic [31:0]   loS;
  logic          stageWe;

  logic          isMul;
  logic          isDiv;
  logic          sMul;
  logic          sDiv;
  logic [63:0]   mulA;
  logic [63:0]   mulB;
  logic [63:0]   product;
  logic          aNeg;
  logic          bNeg;
  logic [31:0]   divA;
  logic [31:0]   divB;
  logic [31:0]   divBSafe;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic          divZero;

  assign isMul = (E_mdu_op == OpMult) |
                 (E_mdu_op == OpMultu);
  assign isDiv = (E_mdu_op == OpDiv) |
                 (E_mdu_op == OpDivu);
  assign sMul  = (E_mdu_op == OpMult);
  assign sDiv  = (E_mdu_op == OpDiv);

  // Sign-extend only for the signed multiply.
  assign mulA = {{32{sMul & E_rs_data[31]}},
                 E_rs_data};
  assign mulB = {{32{sMul & E_rt_data[31]}},
                 E_rt_data};
  assign product = mulA * mulB;

  // Divide on magnitudes, then fix signs: this
  // keeps 0x80000000 / -1 well defined.
  assign aNeg = sDiv & E_rs_data[31];
  assign bNeg = sDiv & E_rt_data[31];
  assign divA = aNeg ? (32'd0 - E_rs_data)
                     : E_rs_data;
  assign divB = bNeg ? (32'd0 - E_rt_data)
                     : E_rt_data;
  assign divZero  = (E_rt_data == 32'd0);
  assign divBSafe = divZero ? 32'd1 : divB;
  assign uq = divA / divBSafe;
  assign ur = divA % divBSafe;
  assign quot = (aNeg ^ bNeg) ? (32'd0 - uq) : uq;
  assign rem  = aNeg ? (32'd0 - ur) : ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      busy    <= 1'b0;
      hiS     <= '0;
      loS     <= '0;
      stageWe <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (count != '0) begin
      count <= count - CW'(1);
      busy  <= (count != CW'(1));
      if (count == CW'(1) && stageWe) begin
        HI <= hiS;
        LO <= loS;
      end
    end else if (E_mdu_start && isMul) begin
      count   <= CW'(MULT_CYCLES);
      busy    <= 1'b1;
      hiS     <= product[63:32];
      loS     <= product[31:0];
      stageWe <= 1'b1;
    end else if (E_mdu_start && isDiv) begin
      count   <= CW'(DIV_CYCLES);
      busy    <= 1'b1;
      hiS     <= rem;
      loS     <= quot;
      stageWe <= !divZero;
    end else if (E_mdu_op == OpMthi) begin
      HI <= E_rs_data;
    end else if (E_mdu_op == OpMtlo) begin
      LO <= E_rs_data;
    end
  end

  assign E_mdu_busy  = busy;
  assign E_mdu_stall = D_mdu_use &
                       (busy | E_mdu_start);

  always_comb begin
    E_mdu_result = '0;
    case (E_mdu_op)
      OpMfhi:  E_mdu_result = HI;
      OpMflo:  E_mdu_result = LO;
      default: E_mdu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: vector table + scoreboard
// plus hand sequences for div0, MT, stall, reset.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  op;
  logic        start;
  logic        dUse;
  logic        busy;
  logic        stall;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_rs_data    (rs),
    .E_rt_data    (rt),
    .E_mdu_op     (op),
    .E_mdu_start  (start),
    .D_mdu_use    (dUse),
    .E_mdu_busy   (busy),
    .E_mdu_stall  (stall),
    .E_mdu_result (result),
    .HI           (hi),
    .LO           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Issue op at T0, track busy length, keep HI/LO
  // stable while busy, compare against scoreboard.
  task automatic issue(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input int cyc);
    exp_t e;
    logic [31:0] h0;
    logic [31:0] l0;
    int n;
    h0 = hi;
    l0 = lo;
    e.hi = eh;
    e.lo = el;
    sbq.push_back(e);
    op = o;
    rs = a;
    rt = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
    n = 0;
    while (busy && n < 50) begin
      if (hi !== h0 || lo !== l0)
        chk("stable", {hi, lo}, {h0, l0});
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_len", 64'(n), 64'(cyc));
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("hi", {32'd0, hi}, {32'd0, e.hi});
      chk("lo", {32'd0, lo}, {32'd0, e.lo});
    end
  endtask

  task automatic mt(input logic [3:0] o,
                    input logic [31:0] v);
    op = o;
    rs = v;
    @(posedge clk);
    #1;
    op = 4'd0;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vt[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,
              32'h00000001, 32'hFFFFFFFE, 5};
    vt[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3] = '{4'd4, 32'd7, 32'd2,
              32'd1, 32'd3, 10};
    vt[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000, 10};
    vt[5] = '{4'd1, 32'd7, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vt[6] = '{4'd3, 32'd7, 32'hFFFFFFFE,
              32'd1, 32'hFFFFFFFD, 10};
    vt[7] = '{4'd4, 32'hFFFFFFFF, 32'd16,
              32'd15, 32'h0FFFFFFF, 10};
    vt[8] = '{4'd2, 32'h00010000, 32'h00010000,
              32'd1, 32'd0, 5};

    reset = 1'b0;
    rs = '0;
    rt = '0;
    op = '0;
    start = 1'b0;
    dUse = 1'b0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      issue(vt[i].op, vt[i].rs, vt[i].rt,
            vt[i].hi, vt[i].lo, vt[i].cyc);
      op = 4'd5;
      #1;
      chk("mfhi", {32'd0, result},
          {32'd0, vt[i].hi});
      op = 4'd6;
      #1;
      chk("mflo", {32'd0, result},
          {32'd0, vt[i].lo});
      op = 4'd0;
      #1;
      chk("res_none", {32'd0, result}, 64'd0);
    end

    // Divide by zero leaves HI/LO as they were.
    mt(4'd7, 32'h1234);
    mt(4'd8, 32'h1234);
    chk("mt_hi", {32'd0, hi}, 64'h1234);
    chk("mt_lo", {32'd0, lo}, 64'h1234);
    issue(4'd3, 32'd99, 32'd0,
          32'h1234, 32'h1234, 10);
    issue(4'd4, 32'd99, 32'd0,
          32'h1234, 32'h1234, 10);
    mt(4'd7, 32'hAA);
    chk("mthi_aa", {32'd0, hi}, 64'hAA);
    chk("mthi_lo", {32'd0, lo}, 64'h1234);

    // Start with an invalid op does nothing.
    op = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
    chk("bad_op", {63'd0, busy}, 64'd0);

    // Stall: start cycle, busy, and D not using.
    dUse = 1'b1;
    #1;
    chk("stall_idle", {63'd0, stall}, 64'd0);
    op = 4'd2;
    rs = 32'd3;
    rt = 32'd5;
    start = 1'b1;
    #1;
    chk("stall_start", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
    chk("stall_busy", {63'd0, stall}, 64'd1);
    // MTLO while busy must be ignored.
    op = 4'd8;
    rs = 32'h5555;
    @(posedge clk);
    #1;
    op = 4'd0;
    chk("mt_busy", {32'd0, lo}, 64'h1234);
    dUse = 1'b0;
    #1;
    chk("stall_nouse", {63'd0, stall}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mulu_busy", {63'd0, busy}, 64'd0);
    chk("mulu_lo", {32'd0, lo}, 64'd15);

    // Async reset mid-divide aborts it.
    op = 4'd3;
    rs = 32'd100;
    rt = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'd0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_hi", {32'd0, hi}, 64'd0);
    chk("ar_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("ar_busy2", {63'd0, busy}, 64'd0);
    chk("ar_hi2", {32'd0, hi}, 64'd0);
    chk("ar_lo2", {32'd0, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
